// File: rtl/modulo_escalonador_rolhas.sv
// rtl/modulo_escalonador_rolhas.sv - cork stock sequencer: primary refill and operator load/unload
// Optional operator removal from secondary is enabled by defining ROLHAS_RETIRADA_EN.
module modulo_escalonador_rolhas #(
   parameter int CAP_MAX    = 99,
   parameter int MIN_PRI    = 5,
   parameter int QTD_TRANSF = 20
) (
   input  logic       clk,
   input  logic       Nclr,
   input  logic       consome,
   input  logic       op_req,
   input  logic       op_sub,
   input  logic [6:0] op_qtd,
   output logic [6:0] prim,
   output logic [6:0] sec,
   output logic       ro,
   output logic       min_signal,
   output logic       busy,
   output logic       op_ack,
   output logic       op_err,
   output logic [1:0] estado
);

   typedef enum logic [1:0] {
      OCIOSO = 2'b00,
      TRANSF = 2'b01,
      OPER   = 2'b10
   } estado_t;

   localparam logic [6:0] CAP7   = 7'(CAP_MAX);
   localparam logic [7:0] CAP8   = 8'(CAP_MAX);
   localparam logic [6:0] MIN7   = 7'(MIN_PRI);
   localparam logic [6:0] TRANS7 = 7'(QTD_TRANSF);

   estado_t    estado_q;
   logic [6:0] restante;
   logic       sub_r;
   logic       sub_eff;
   logic       rejeita;
   logic [6:0] folga_prim;
   logic [6:0] lim_sec;
   logic [6:0] qtd_transf;
   logic [7:0] soma_sec;

`ifdef ROLHAS_RETIRADA_EN
   assign sub_eff = op_sub;
`else
   logic unused_op_sub;
   assign unused_op_sub = op_sub;
   assign sub_eff = 1'b0;
`endif

   assign ro         = (prim == 7'd0);
   assign min_signal = (prim < MIN7);
   assign busy       = (estado_q != OCIOSO);
   assign estado     = estado_q;

   // Refill size is bounded by both the reservoir and the room left in primary.
   assign folga_prim = CAP7 - prim;
   assign lim_sec    = (TRANS7 < sec) ? TRANS7 : sec;
   assign qtd_transf = (lim_sec < folga_prim) ? lim_sec : folga_prim;

   assign soma_sec = {1'b0, sec} + {1'b0, op_qtd};
   assign rejeita  = sub_eff ? (op_qtd > sec) : (soma_sec > CAP8);

   always_ff @(posedge clk or negedge Nclr) begin
      if (!Nclr) begin
         estado_q <= OCIOSO;
         prim     <= 7'd0;
         sec      <= 7'd0;
         restante <= 7'd0;
         sub_r    <= 1'b0;
         op_ack   <= 1'b0;
         op_err   <= 1'b0;
      end else begin
         op_ack <= 1'b0;
         op_err <= 1'b0;
         case (estado_q)
            OCIOSO: begin
               if (min_signal && (sec != 7'd0)) begin
                  estado_q <= TRANSF;
                  restante <= qtd_transf;
               end else if (op_req) begin
                  if (rejeita) begin
                     op_err <= 1'b1;
                  end else if (op_qtd == 7'd0) begin
                     op_ack <= 1'b1;
                  end else begin
                     estado_q <= OPER;
                     restante <= op_qtd;
                     sub_r    <= sub_eff;
                  end
               end
            end
            TRANSF: begin
               sec      <= sec - 7'd1;
               restante <= restante - 7'd1;
               // A cork consumed while one arrives leaves primary unchanged.
               if (!consome) prim <= prim + 7'd1;
               if (restante == 7'd1) estado_q <= OCIOSO;
            end
            OPER: begin
               sec      <= sub_r ? (sec - 7'd1) : (sec + 7'd1);
               restante <= restante - 7'd1;
               if (restante == 7'd1) begin
                  estado_q <= OCIOSO;
                  op_ack   <= 1'b1;
               end
            end
            default: estado_q <= OCIOSO;
         endcase
         if ((estado_q != TRANSF) && consome && (prim != 7'd0)) prim <= prim - 7'd1;
      end
   end

endmodule

// File: tb/tb_modulo_escalonador_rolhas.sv
// tb/tb_modulo_escalonador_rolhas.sv - directed bench for modulo_escalonador_rolhas
module tb_modulo_escalonador_rolhas;

   logic       clk = 1'b0;
   logic       Nclr;
   logic       consome;
   logic       op_req;
   logic       op_sub;
   logic [6:0] op_qtd;
   logic [6:0] prim;
   logic [6:0] sec;
   logic       ro;
   logic       min_signal;
   logic       busy;
   logic       op_ack;
   logic       op_err;
   logic [1:0] estado;

   int total = 0;
   int bad   = 0;
   int cyc;
   int n;
   logic got_ack, got_err;
   logic [1:0] est1;

   always #5 clk = ~clk;

   modulo_escalonador_rolhas dut (
      .clk(clk), .Nclr(Nclr), .consome(consome), .op_req(op_req), .op_sub(op_sub),
      .op_qtd(op_qtd), .prim(prim), .sec(sec), .ro(ro), .min_signal(min_signal),
      .busy(busy), .op_ack(op_ack), .op_err(op_err), .estado(estado)
   );

   task automatic chk(input string tag, input int obs, input int expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic op_run(input logic sub, input int qtd, output int cycles,
                         output logic ack, output logic err);
      op_sub = sub;
      op_qtd = 7'(qtd);
      op_req = 1'b1;
      ack = 1'b0;
      err = 1'b0;
      cycles = 300;
      for (int i = 1; i <= 300; i++) begin
         step();
         if (op_ack || op_err) begin
            ack = op_ack;
            err = op_err;
            cycles = i;
            break;
         end
      end
      op_req = 1'b0;
   endtask

   task automatic do_reset();
      Nclr = 1'b0;
      #3;
      Nclr = 1'b1;
      step();
   endtask

   initial begin
      Nclr = 1'b0; consome = 1'b0; op_req = 1'b0; op_sub = 1'b0; op_qtd = 7'd0;
      @(posedge clk); #1;
      chk("rst_prim", prim, 0);
      chk("rst_sec", sec, 0);
      chk("rst_ro", ro, 1);
      chk("rst_min", min_signal, 1);
      chk("rst_estado", estado, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ack", op_ack, 0);
      chk("rst_err", op_err, 0);
      Nclr = 1'b1;
      step();

      // add 30: accept edge, then 30 updates, ack on the last
      op_sub = 1'b0; op_qtd = 7'd30; op_req = 1'b1;
      step();
      chk("s1_accept_estado", estado, 2);
      chk("s1_accept_sec", sec, 0);
      chk("s1_busy", busy, 1);
      for (int k = 1; k <= 30; k++) begin
         step();
         if (k == 15) chk("s1_mid_sec", sec, 15);
         if (k == 29) chk("s1_no_early_ack", op_ack, 0);
      end
      chk("s1_ack", op_ack, 1);
      chk("s1_sec", sec, 30);
      chk("s1_estado_idle", estado, 0);
      op_req = 1'b0;
      step();
      chk("s1_ack_single", op_ack, 0);
      chk("s1_refill_estado", estado, 1);
      chk("s1_refill_prim0", prim, 0);
      for (int k = 1; k <= 20; k++) begin
         step();
         if (k == 10) chk("s1_refill_mid_prim", prim, 10);
         if (k == 19) chk("s1_refill_still", estado, 1);
      end
      chk("s1_refill_done", estado, 0);
      chk("s1_prim", prim, 20);
      chk("s1_sec_after", sec, 10);

      // overflow reject and exact-capacity boundary
      op_run(1'b0, 85, cyc, got_ack, got_err);
      chk("s2_load_ack", got_ack, 1);
      chk("s2_load_cyc", cyc, 86);
      chk("s2_load_sec", sec, 95);
      op_run(1'b0, 10, cyc, got_ack, got_err);
      chk("s2_err", got_err, 1);
      chk("s2_err_cyc", cyc, 1);
      chk("s2_err_sec", sec, 95);
      step();
      chk("s2_err_single", op_err, 0);
      op_run(1'b0, 4, cyc, got_ack, got_err);
      chk("s2_cap_ack", got_ack, 1);
      chk("s2_cap_sec", sec, 99);
      op_run(1'b0, 0, cyc, got_ack, got_err);
      chk("s2_zero_ack", got_ack, 1);
      chk("s2_zero_cyc", cyc, 1);
      chk("s2_zero_sec", sec, 99);
      chk("s2_zero_estado", estado, 0);

      // reset in the middle of an operation
      do_reset();
      op_sub = 1'b0; op_qtd = 7'd50; op_req = 1'b1;
      for (int k = 0; k < 5; k++) step();
      chk("rm_sec_before", sec, 4);
      Nclr = 1'b0;
      #1;
      chk("rm_sec", sec, 0);
      chk("rm_estado", estado, 0);
      chk("rm_ack", op_ack, 0);
      op_req = 1'b0;
      #2;
      Nclr = 1'b1;
      step();

      // small refill limited by the reservoir
      op_run(1'b0, 8, cyc, got_ack, got_err);
      chk("s3_load_sec", sec, 8);
      n = 0;
      do begin step(); n++; end while (estado != 2'd0 && n < 50);
      chk("s3_refill_cycles", n, 9);
      chk("s3_prim", prim, 8);
      chk("s3_sec", sec, 0);
      chk("s3_ro", ro, 0);
      chk("s3_min", min_signal, 0);

      // consumption during refill keeps primary constant
      op_run(1'b0, 30, cyc, got_ack, got_err);
      chk("s4_load_sec", sec, 30);
      consome = 1'b1;
      for (int k = 0; k < 4; k++) step();
      consome = 1'b0;
      chk("s4_prim_low", prim, 4);
      step();
      chk("s4_transf", estado, 1);
      consome = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         step();
         if (k == 7) begin
            chk("s4_prim_const", prim, 4);
            chk("s4_sec_dec", sec, 23);
         end
      end
      consome = 1'b0;
      chk("s4_prim_end", prim, 4);
      chk("s4_sec_end", sec, 10);
      n = 0;
      do begin step(); n++; end while (estado != 2'd0 && n < 50);
      chk("s4_second_refill", n, 11);
      chk("s4_prim_final", prim, 14);
      chk("s4_sec_final", sec, 0);

      // refill wins over a simultaneous operator request
      op_run(1'b0, 20, cyc, got_ack, got_err);
      consome = 1'b1;
      for (int k = 0; k < 10; k++) step();
      consome = 1'b0;
      chk("s5_prim", prim, 4);
      op_sub = 1'b0; op_qtd = 7'd7; op_req = 1'b1;
      n = 0; est1 = 2'd3;
      do begin
         step(); n++;
         if (n == 1) est1 = estado;
      end while (!op_ack && n < 100);
      op_req = 1'b0;
      chk("s5_first_transf", est1, 1);
      chk("s5_ack_cycle", n, 29);
      chk("s5_prim_end", prim, 24);
      chk("s5_sec_end", sec, 7);

      // removal (or add when removal is compiled out)
      op_run(1'b0, 3, cyc, got_ack, got_err);
      chk("s6_sec10", sec, 10);
`ifdef ROLHAS_RETIRADA_EN
      op_run(1'b1, 11, cyc, got_ack, got_err);
      chk("s6_sub_err", got_err, 1);
      chk("s6_sub_err_sec", sec, 10);
      op_run(1'b1, 4, cyc, got_ack, got_err);
      chk("s6_sub_ack", got_ack, 1);
      chk("s6_sub_sec", sec, 6);
`else
      op_run(1'b1, 4, cyc, got_ack, got_err);
      chk("s6_sub_ack", got_ack, 1);
      chk("s6_sub_as_add", sec, 14);
`endif
      chk("s6_cyc", cyc, 5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
